// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S multicycle processor datapath:
// widths, instruction opcodes, ALU operation codes and the decoded
// instruction enum handed to the control unit.
package k_and_s_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 5;
    localparam int NUM_REGS  = 4;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    // Opcode byte found in ir[15:8]
    localparam logic [7:0] OPC_NOP    = 8'h00;
    localparam logic [7:0] OPC_LOAD   = 8'h81;
    localparam logic [7:0] OPC_STORE  = 8'h82;
    localparam logic [7:0] OPC_MOVE   = 8'h91;
    localparam logic [7:0] OPC_ADD    = 8'hA1;
    localparam logic [7:0] OPC_SUB    = 8'hA2;
    localparam logic [7:0] OPC_AND    = 8'hA3;
    localparam logic [7:0] OPC_OR     = 8'hA4;
    localparam logic [7:0] OPC_BRANCH = 8'h01;
    localparam logic [7:0] OPC_BZERO  = 8'h02;
    localparam logic [7:0] OPC_BNZERO = 8'h03;
    localparam logic [7:0] OPC_BNEG   = 8'h0A;
    localparam logic [7:0] OPC_BNNEG  = 8'h0B;
    localparam logic [7:0] OPC_HALT   = 8'hFF;

    // ALU operation select driven by the control unit
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_HALT
    } decoded_instruction_type;

endpackage

// File: rtl/data_path_if.sv
// Bundle of everything passing between the control unit / RAM side and the
// datapath: control strobes in, decode and flags out, and the RAM bus.
interface data_path_if;
    import k_and_s_pkg::*;

    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    write_reg_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    flags_reg_enable;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic [ADDR_W-1:0]       ram_addr;
    logic [DATA_W-1:0]       data_out;
    logic [DATA_W-1:0]       data_in;

    // Control unit plus RAM model side
    modport master (
        output branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
               c_sel, operation, flags_reg_enable, data_in,
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out
    );

    // Datapath side
    modport slave (
        input  branch, pc_enable, ir_enable, write_reg_enable, addr_sel,
               c_sel, operation, flags_reg_enable, data_in,
        output decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, ram_addr, data_out
    );

endinterface

// File: rtl/data_path_alu.sv
// Combinational ALU: add/sub/and/or on two DATA_W operands, producing the
// wrapped result and the four status flags. AND/OR never report overflow.
module alu
    import k_and_s_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [1:0]        i_operation,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_unsigned_overflow,
    output logic              o_signed_overflow
);

    logic [DATA_W:0] w_wide;

    // The extra top bit of the widened add/sub is the carry (add) or borrow (sub)
    always_comb begin
        w_wide              = '0;
        o_unsigned_overflow = 1'b0;
        o_signed_overflow   = 1'b0;
        case (i_operation)
            OP_ADD: begin
                w_wide              = {1'b0, i_a} + {1'b0, i_b};
                o_unsigned_overflow = w_wide[DATA_W];
                o_signed_overflow   = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                                      (w_wide[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_SUB: begin
                w_wide              = {1'b0, i_a} - {1'b0, i_b};
                o_unsigned_overflow = w_wide[DATA_W];
                o_signed_overflow   = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                                      (w_wide[DATA_W-1] != i_a[DATA_W-1]);
            end
            OP_AND:  w_wide = {1'b0, i_a & i_b};
            default: w_wide = {1'b0, i_a | i_b};
        endcase
    end

    assign o_result = w_wide[DATA_W-1:0];
    assign o_zero   = (w_wide[DATA_W-1:0] == '0);
    assign o_neg    = w_wide[DATA_W-1];

endmodule

// File: rtl/data_path.sv
// K&S multicycle datapath: PC, IR, register file, ALU and flags register.
// Every piece of state moves only on an edge where its strobe is high;
// the decoder and RAM address mux are purely combinational from state.
module data_path
    import k_and_s_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    data_path_if.slave   bus
);

    logic [ADDR_W-1:0]    r_pc;
    logic [DATA_W-1:0]    r_ir;
    logic [DATA_W-1:0]    r_regs [NUM_REGS];
    logic                 r_zero;
    logic                 r_neg;
    logic                 r_uovf;
    logic                 r_sovf;

    decoded_instruction_type w_decoded;
    logic [REG_IDX_W-1:0] w_ra_idx;
    logic [REG_IDX_W-1:0] w_rb_idx;
    logic [REG_IDX_W-1:0] w_rd_idx;
    logic [DATA_W-1:0]    w_bus_a;
    logic [DATA_W-1:0]    w_bus_b;
    logic [DATA_W-1:0]    w_alu_result;
    logic [DATA_W-1:0]    w_wb_data;
    logic                 w_alu_zero;
    logic                 w_alu_neg;
    logic                 w_alu_uovf;
    logic                 w_alu_sovf;
    logic                 w_unused_ir_bit;

    // IR bit 7 is not part of any instruction field
    assign w_unused_ir_bit = r_ir[7];

    // Opcode byte to decoded instruction; unknown opcodes behave as NOP
    always_comb begin
        w_decoded = I_NOP;
        case (r_ir[15:8])
            OPC_LOAD:   w_decoded = I_LOAD;
            OPC_STORE:  w_decoded = I_STORE;
            OPC_MOVE:   w_decoded = I_MOVE;
            OPC_ADD:    w_decoded = I_ADD;
            OPC_SUB:    w_decoded = I_SUB;
            OPC_AND:    w_decoded = I_AND;
            OPC_OR:     w_decoded = I_OR;
            OPC_BRANCH: w_decoded = I_BRANCH;
            OPC_BZERO:  w_decoded = I_BZERO;
            OPC_BNZERO: w_decoded = I_BNZERO;
            OPC_BNEG:   w_decoded = I_BNEG;
            OPC_BNNEG:  w_decoded = I_BNNEG;
            OPC_HALT:   w_decoded = I_HALT;
            default:    w_decoded = I_NOP;
        endcase
    end

    // Register field positions differ for LOAD/STORE/MOVE; ALU layout is the default
    always_comb begin
        w_ra_idx = r_ir[3:2];
        w_rd_idx = r_ir[5:4];
        case (r_ir[15:8])
            OPC_LOAD:  w_rd_idx = r_ir[6:5];
            OPC_STORE: w_ra_idx = r_ir[6:5];
            OPC_MOVE: begin
                w_rd_idx = r_ir[3:2];
                w_ra_idx = r_ir[1:0];
            end
            default: ;
        endcase
    end

    // rb always sits in ir[1:0], which is also where MOVE keeps ra, so a
    // MOVE issued with OR yields ra | ra = ra
    assign w_rb_idx  = r_ir[1:0];
    assign w_bus_a   = r_regs[w_ra_idx];
    assign w_bus_b   = r_regs[w_rb_idx];
    assign w_wb_data = bus.c_sel ? bus.data_in : w_alu_result;

    alu u_alu (
        .i_a                 (w_bus_a),
        .i_b                 (w_bus_b),
        .i_operation         (bus.operation),
        .o_result            (w_alu_result),
        .o_zero              (w_alu_zero),
        .o_neg               (w_alu_neg),
        .o_unsigned_overflow (w_alu_uovf),
        .o_signed_overflow   (w_alu_sovf)
    );

    // PC either jumps to the IR address field or steps by one, wrapping at the top
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else if (bus.pc_enable) begin
            r_pc <= bus.branch ? r_ir[ADDR_W-1:0] : r_pc + ADDR_W'(1);
        end
    end

    // Instruction fetch straight from the RAM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if (bus.ir_enable) begin
            r_ir <= bus.data_in;
        end
    end

    // Register file write-back; reads are combinational and see the old value this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.write_reg_enable) begin
            r_regs[w_rd_idx] <= w_wb_data;
        end
    end

    // Flags capture the current ALU outcome only when asked, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
            r_uovf <= 1'b0;
            r_sovf <= 1'b0;
        end else if (bus.flags_reg_enable) begin
            r_zero <= w_alu_zero;
            r_neg  <= w_alu_neg;
            r_uovf <= w_alu_uovf;
            r_sovf <= w_alu_sovf;
        end
    end

    assign bus.decoded_instruction = w_decoded;
    assign bus.zero_op             = r_zero;
    assign bus.neg_op              = r_neg;
    assign bus.unsigned_overflow   = r_uovf;
    assign bus.signed_overflow     = r_sovf;
    assign bus.ram_addr            = bus.addr_sel ? r_pc : r_ir[ADDR_W-1:0];
    assign bus.data_out            = w_bus_a;

endmodule
